fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_pkg.sv | 12 +
 rtl/fetch_pc_unit_npc_target_sel.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and FSM state type for the fetch PC unit.
package fetch_pc_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } pc_state_t;

endpackage

// File: rtl/fetch_pc_unit_npc_target_sel.sv
// Next-PC target computation and priority select: exc > eret > jump > jr > branch.
// Sequential fallback (pc + 4 or held target) is resolved by the caller.
module npc_target_sel #(
   parameter int unsigned       WIDTH      = 32,
   parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(32'h0000_4180)
) (
   input  logic             exc,
   input  logic             eret,
   input  logic             branch,
   input  logic             jump,
   input  logic             jr,
   input  logic [WIDTH-1:0] pc_br,
   input  logic [15:0]      imm16,
   input  logic [25:0]      imm26,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] epc,
   output logic             trap_valid,
   output logic [WIDTH-1:0] trap_target,
   output logic             redir_valid,
   output logic [WIDTH-1:0] redir_target
);

   logic [WIDTH-1:0] pc_br_plus4;
   logic [WIDTH-1:0] branch_offset;
   logic [WIDTH-1:0] branch_target;
   logic [WIDTH-1:0] jump_target;

   // Branch offset is in words; jump keeps the region bits of the delay-slot PC.
   always_comb begin
      pc_br_plus4   = pc_br + WIDTH'(4);
      branch_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
      branch_target = pc_br_plus4 + branch_offset;
      jump_target   = {pc_br_plus4[WIDTH-1:28], imm26, 2'b00};

      trap_valid  = exc | eret;
      trap_target = exc ? EXC_VECTOR : epc;

      redir_valid = jump | jr | branch;
      if (jump)
         redir_target = jump_target;
      else if (jr)
         redir_target = rs_data;
      else
         redir_target = branch_target;
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with stall-tolerant redirect holding and exception entry/return.
// Define FETCH_PC_EXC_EN to enable exc/eret/epc; otherwise they are ignored and epc stays 0.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned       WIDTH      = 32,
   parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
   parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch,
   input  logic             jump,
   input  logic             jr,
   input  logic [WIDTH-1:0] pc_br,
   input  logic [15:0]      imm16,
   input  logic [25:0]      imm26,
   input  logic [WIDTH-1:0] rs_data,
   input  logic             exc,
   input  logic             eret,
   input  logic [WIDTH-1:0] exc_pc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] epc,
   output logic             redirect_pending
);

   pc_state_t        state_q, state_next;
   logic [WIDTH-1:0] pc_q, pc_next;
   logic [WIDTH-1:0] epc_q, epc_next;
   logic [WIDTH-1:0] held_q, held_next;

   logic             exc_take;
   logic             eret_take;
   logic             trap_valid;
   logic [WIDTH-1:0] trap_target;
   logic             redir_valid;
   logic [WIDTH-1:0] redir_target;

`ifdef FETCH_PC_EXC_EN
   assign exc_take  = exc;
   assign eret_take = eret;
`else
   logic unused_exc_inputs;
   assign unused_exc_inputs = exc ^ eret;
   assign exc_take  = 1'b0;
   assign eret_take = 1'b0;
`endif

   npc_target_sel #(
      .WIDTH      (WIDTH),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_npc_target_sel (
      .exc          (exc_take),
      .eret         (eret_take),
      .branch       (branch),
      .jump         (jump),
      .jr           (jr),
      .pc_br        (pc_br),
      .imm16        (imm16),
      .imm26        (imm26),
      .rs_data      (rs_data),
      .epc          (epc_q),
      .trap_valid   (trap_valid),
      .trap_target  (trap_target),
      .redir_valid  (redir_valid),
      .redir_target (redir_target)
   );

   assign pc_plus4 = pc_q + WIDTH'(4);

   // Traps bypass stall; a stalled redirect parks in held_q until the stall lifts,
   // and a fresh redirect on the release cycle beats the parked one.
   always_comb begin
      state_next = state_q;
      pc_next    = pc_q;
      epc_next   = epc_q;
      held_next  = held_q;

      if (trap_valid) begin
         pc_next    = trap_target;
         state_next = IDLE;
         held_next  = '0;
         if (exc_take)
            epc_next = exc_pc;
      end else if (stall) begin
         if (redir_valid) begin
            held_next  = redir_target;
            state_next = HOLD;
         end
      end else begin
         if (redir_valid)
            pc_next = redir_target;
         else if (state_q == HOLD)
            pc_next = held_q;
         else
            pc_next = pc_plus4;
         state_next = IDLE;
         held_next  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         held_q  <= '0;
      end else begin
         state_q <= state_next;
         pc_q    <= pc_next;
         epc_q   <= epc_next;
         held_q  <= held_next;
      end
   end

   assign pc               = pc_q;
   assign epc              = epc_q;
   assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; expectations track FETCH_PC_EXC_EN.
module tb_fetch_pc_unit;

`ifdef FETCH_PC_EXC_EN
   localparam bit EXC_ON = 1'b1;
`else
   localparam bit EXC_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch;
   logic        jump;
   logic        jr;
   logic [31:0] pc_br;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] rs_data;
   logic        exc;
   logic        eret;
   logic [31:0] exc_pc;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] epc;
   logic        redirect_pending;

   int checks;
   int failures;

   fetch_pc_unit dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .branch           (branch),
      .jump             (jump),
      .jr               (jr),
      .pc_br            (pc_br),
      .imm16            (imm16),
      .imm26            (imm26),
      .rs_data          (rs_data),
      .exc              (exc),
      .eret             (eret),
      .exc_pc           (exc_pc),
      .pc               (pc),
      .pc_plus4         (pc_plus4),
      .epc              (epc),
      .redirect_pending (redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then let the edge happen and settle before checks.
   task automatic applyStimulus(
      input logic        rst_i,
      input logic        stall_i,
      input logic        branch_i,
      input logic        jump_i,
      input logic        jr_i,
      input logic        exc_i,
      input logic        eret_i,
      input logic [31:0] pc_br_i,
      input logic [15:0] imm16_i,
      input logic [25:0] imm26_i,
      input logic [31:0] rs_data_i,
      input logic [31:0] exc_pc_i
   );
      @(negedge clk);
      reset   = rst_i;
      stall   = stall_i;
      branch  = branch_i;
      jump    = jump_i;
      jr      = jr_i;
      exc     = exc_i;
      eret    = eret_i;
      pc_br   = pc_br_i;
      imm16   = imm16_i;
      imm26   = imm26_i;
      rs_data = rs_data_i;
      exc_pc  = exc_pc_i;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
      exc = 1'b0; eret = 1'b0; pc_br = '0; imm16 = '0; imm26 = '0;
      rs_data = '0; exc_pc = '0;

      // Reset with every control input active must still land on RESET_PC.
      applyStimulus(1, 1, 1, 1, 1, 1, 1, 32'h3010, 16'h0001, 26'h1, 32'h5000, 32'h3333);
      checkOutput("reset_pc", pc, 32'h0000_3000);
      checkOutput("reset_epc", epc, 32'h0);
      checkOutput("reset_pending", {31'b0, redirect_pending}, 32'h0);
      checkOutput("reset_pc_plus4", pc_plus4, 32'h0000_3004);

      idleCycle(); checkOutput("seq1", pc, 32'h0000_3004);
      idleCycle(); checkOutput("seq2", pc, 32'h0000_3008);
      idleCycle(); checkOutput("seq3", pc, 32'h0000_300C);

      // 0x3014 + (-4 words) = 0x3004
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h0);
      checkOutput("branch_back", pc, 32'h0000_3004);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 32'h0);
      checkOutput("jump", pc, 32'h0000_3040);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 32'h3010, 16'hFFFC, 26'h0000C20, 32'h0, 32'h0);
      checkOutput("jump_over_branch", pc, 32'h0000_3080);

      // Stalled jr is parked, then released after two more stalled cycles.
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h3100, 32'h0);
      checkOutput("stall_hold_pc", pc, 32'h0000_3080);
      checkOutput("stall_pending", {31'b0, redirect_pending}, 32'h1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
      checkOutput("stall3_pc", pc, 32'h0000_3080);
      checkOutput("stall3_pending", {31'b0, redirect_pending}, 32'h1);
      idleCycle();
      checkOutput("release_pc", pc, 32'h0000_3100);
      checkOutput("release_pending", {31'b0, redirect_pending}, 32'h0);

      // Newer stalled branch (0x3104 + 0x40) overwrites the parked jr target.
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h3200, 32'h0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h3100, 16'h0010, 26'h0, 32'h0, 32'h0);
      checkOutput("hold_overwrite_pc", pc, 32'h0000_3100);
      idleCycle();
      checkOutput("hold_overwrite_release", pc, 32'h0000_3144);

      // A redirect on the release cycle beats the parked target.
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h3300, 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h3144, 16'h0, 26'h0000D00, 32'h0, 32'h0);
      checkOutput("release_new_redirect", pc, 32'h0000_3400);

      // Exception during stall with jr.
      applyStimulus(0, 1, 0, 0, 1, 1, 0, 32'h0, 16'h0, 26'h0, 32'h3500, 32'h3020);
      checkOutput("exc_pc", pc, EXC_ON ? 32'h0000_4180 : 32'h0000_3400);
      checkOutput("exc_epc", epc, EXC_ON ? 32'h0000_3020 : 32'h0);
      checkOutput("exc_pending", {31'b0, redirect_pending}, EXC_ON ? 32'h0 : 32'h1);

      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
      checkOutput("eret_pc", pc, EXC_ON ? 32'h0000_3020 : 32'h0000_3500);
      checkOutput("eret_pending", {31'b0, redirect_pending}, 32'h0);

      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3070);
      checkOutput("exc_eret_pc", pc, EXC_ON ? 32'h0000_4180 : 32'h0000_3504);
      checkOutput("exc_eret_epc", epc, EXC_ON ? 32'h0000_3070 : 32'h0);
      idleCycle();
      checkOutput("after_exc_seq", pc, EXC_ON ? 32'h0000_4184 : 32'h0000_3508);

      // Sequential wrap at the top of the address space.
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);
      checkOutput("wrap_pc_top", pc, 32'hFFFF_FFFC);
      checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
      idleCycle();
      checkOutput("wrap_pc", pc, 32'h0);

      // Reset while parked in HOLD discards the held target.
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h3700, 32'h0);
      checkOutput("pre_reset_pending", {31'b0, redirect_pending}, 32'h1);
      applyStimulus(1, 1, 0, 0, 1, 1, 0, 32'h0, 16'h0, 26'h0, 32'h3700, 32'h3999);
      checkOutput("hold_reset_pc", pc, 32'h0000_3000);
      checkOutput("hold_reset_pending", {31'b0, redirect_pending}, 32'h0);
      checkOutput("hold_reset_epc", epc, 32'h0);
      idleCycle();
      checkOutput("post_reset_seq", pc, 32'h0000_3004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
